// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: hazard inputs from the pipeline and the pipeline-register controls driven back to it.
interface hazard_stall_ctrl_if #(parameter int CNT_W = 16);
    logic [2:0] read_reg1_IF_ID;
    logic [2:0] read_reg2_IF_ID;
    logic rd1_used_IF_ID;
    logic rd2_used_IF_ID;
    logic [2:0] w1_reg_ID_EX;
    logic reg_en_ID_EX;
    logic mem_en_ID_EX;
    logic mem_wr_ID_EX;
    logic branch_taken_EX;
    logic imem_stall;
    logic dmem_stall;
    logic dmem_done;
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic [CNT_W-1:0] stall_cnt;
    logic timeout_err;
    modport master (
        output read_reg1_IF_ID, read_reg2_IF_ID, rd1_used_IF_ID, rd2_used_IF_ID,
        output w1_reg_ID_EX, reg_en_ID_EX, mem_en_ID_EX, mem_wr_ID_EX,
        output branch_taken_EX, imem_stall, dmem_stall, dmem_done,
        input pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        input if_id_flush, id_ex_flush, stall_cnt, timeout_err
    );
    modport slave (
        input read_reg1_IF_ID, read_reg2_IF_ID, rd1_used_IF_ID, rd2_used_IF_ID,
        input w1_reg_ID_EX, reg_en_ID_EX, mem_en_ID_EX, mem_wr_ID_EX,
        input branch_taken_EX, imem_stall, dmem_stall, dmem_done,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        output if_id_flush, id_ex_flush, stall_cnt, timeout_err
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: stall/bubble/flush control for the five-stage pipeline
// (load-use bubble, dcache freeze, icache fetch bubble, branch flush).
module hazard_stall_ctrl #(
    parameter int CNT_W = 16,
    parameter int MAX_WAIT = 255
) (
    input logic clk,
    input logic rst_n,
    hazard_stall_ctrl_if.slave bus
);
    localparam logic [1:0] RUN = 2'd0, DWAIT = 2'd1, IWAIT = 2'd2;
    localparam int WW = $clog2(MAX_WAIT + 1);
    logic [1:0] state, state_nx;
    logic [WW-1:0] wait_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic timeout_err, load_use, dwait, frz;
    logic [6:0] ctl;
    assign load_use = bus.mem_en_ID_EX & ~bus.mem_wr_ID_EX & bus.reg_en_ID_EX &
        ((bus.rd1_used_IF_ID & (bus.w1_reg_ID_EX == bus.read_reg1_IF_ID)) |
         (bus.rd2_used_IF_ID & (bus.w1_reg_ID_EX == bus.read_reg2_IF_ID)));
    assign dwait = state == DWAIT;
    // A completing miss releases the freeze in the same cycle, so dmem_stall is ignored then.
    assign frz = dwait ? ~bus.dmem_done : bus.dmem_stall;
    // ctl = {pc, if_id, id_ex, ex_mem, mem_wb enables, if_id_flush, id_ex_flush}
    always_comb begin
        ctl = !rst_n ? 7'b0000011 :
              frz ? 7'b0000000 :
              bus.branch_taken_EX ? 7'b1111111 :
              load_use ? 7'b0011101 :
              bus.imem_stall ? 7'b0111110 : 7'b1111100;
        state_nx = frz ? DWAIT :
                   (!dwait && !bus.branch_taken_EX && !load_use && bus.imem_stall) ? IWAIT : RUN;
    end
    assign {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
            bus.if_id_flush, bus.id_ex_flush} = ctl;
    assign bus.stall_cnt = stall_cnt;
    assign bus.timeout_err = timeout_err;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            wait_cnt <= '0;
            stall_cnt <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (!ctl[6] && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (dwait && frz) begin
                if (wait_cnt != WW'(MAX_WAIT)) wait_cnt <= wait_cnt + 1'b1;
                if (wait_cnt >= WW'(MAX_WAIT - 1)) timeout_err <= 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end
endmodule
